// File: rtl/wr_fifo_fill.sv
// Write-side fill controller for the dual-clock test FIFO: waits for empty, settles,
// then writes a data pattern until full. Define WR_FIFO_FILL_LFSR_EN for LFSR data.
module wr_fifo_fill #(
    parameter int DATA_W     = 8,
    parameter int START_VAL  = 0,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 3
`ifdef WR_FIFO_FILL_LFSR_EN
    , localparam int DW = 8
`else
    , localparam int DW = DATA_W
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          wrfull,
    input  logic          wrempty,
    output logic          wrreq,
    output logic [DW-1:0] wrdata,
    output logic [7:0]    fill_cnt,
    output logic          busy,
    output logic          led_wr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

`ifdef WR_FIFO_FILL_LFSR_EN
    localparam logic [DW-1:0] SEED = 8'h01;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; all-zero state is unreachable from the seed.
    function automatic logic [DW-1:0] advance(input logic [DW-1:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction
`else
    localparam logic [DW-1:0] SEED = DW'(START_VAL);

    function automatic logic [DW-1:0] advance(input logic [DW-1:0] d);
        return d + DW'(STEP);
    endfunction
`endif

    state_t        state, state_next;
    logic [3:0]    settle_cnt, settle_next;
    logic          wrreq_next, busy_next;
    logic [7:0]    fill_next;
    logic [DW-1:0] data_next;

    assign led_wr = wrempty;

    // State register; the write-port outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            wrreq      <= 1'b0;
            busy       <= 1'b0;
            fill_cnt   <= '0;
            wrdata     <= SEED;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_next;
            settle_cnt <= settle_next;
            wrreq      <= wrreq_next;
            busy       <= busy_next;
            fill_cnt   <= fill_next;
            wrdata     <= data_next;
        end
    end

    // Next-state logic; wrfull takes priority over every other condition.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value unassigned (no latch).
        state_next  = state;
        settle_next = settle_cnt;
        case (state)
            IDLE: begin
                if (!wrfull && en && wrempty) begin
                    state_next  = SETTLE;
                    settle_next = '0;
                end
            end
            SETTLE: begin
                if (wrfull) begin
                    state_next = IDLE;
                end else begin
                    settle_next = settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST) state_next = WRITE;
                end
            end
            WRITE: begin
                if (wrfull) state_next = IDLE;
            end
            default: begin
                state_next  = IDLE;
                settle_next = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        wrreq_next = (state_next == WRITE);
        busy_next  = (state_next == SETTLE) || (state_next == WRITE);
        fill_next  = fill_cnt;
        data_next  = wrdata;
        if (state == WRITE && wrfull) fill_next = fill_cnt + 8'd1;
        // A rejected request keeps its data so it is re-presented on the next fill.
        if (wrreq && !wrfull) data_next = advance(wrdata);
    end

endmodule

// File: tb/tb_wr_fifo_fill.sv
// Self-checking bench for wr_fifo_fill: a 16-deep FIFO model drives the flags and a
// scoreboard queue holds the data each fill must write.
module tb_wr_fifo_fill;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 3;

`ifdef WR_FIFO_FILL_LFSR_EN
    localparam logic [7:0] RESET_VAL = 8'h01;
`else
    localparam logic [7:0] RESET_VAL = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wrfull, wrempty;
    logic       wrreq, busy, led_wr;
    logic [7:0] wrdata, fill_cnt;

    int         checks = 0;
    int         errors = 0;
    int         fifo_cnt = 0;
    int         n_acc = 0;
    bit         full_force = 1'b0;
    logic [7:0] next_val;
    logic [7:0] exp_q[$];

    wr_fifo_fill #(
        .DATA_W    (8),
        .START_VAL (0),
        .STEP      (1),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .wrfull  (wrfull),
        .wrempty (wrempty),
        .wrreq   (wrreq),
        .wrdata  (wrdata),
        .fill_cnt(fill_cnt),
        .busy    (busy),
        .led_wr  (led_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat_next(input logic [7:0] v);
`ifdef WR_FIFO_FILL_LFSR_EN
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
        return v + 8'd1;
`endif
    endfunction

    task automatic update_flags();
        wrfull  = (fifo_cnt >= DEPTH) || full_force;
        wrempty = (fifo_cnt == 0);
    endtask

    task automatic drain();
        fifo_cnt = 0;
        update_flags();
    endtask

    // One write-clock cycle: sample the write port mid-cycle, let the FIFO model react after the edge.
    task automatic tick();
        logic       req, full;
        logic [7:0] d;
        @(negedge clk);
        req  = wrreq;
        full = wrfull;
        d    = wrdata;
        @(posedge clk);
        #1;
        if (req && !full) begin
            n_acc++;
            fifo_cnt++;
            if (exp_q.size() == 0) check("spurious_wr", 32'(req), 32'd0);
            else                   check("wr_data", 32'(d), 32'(exp_q.pop_front()));
            if (d == 8'h00 && RESET_VAL == 8'h01) check("lfsr_zero", 32'(d), 32'h1);
        end else if (req && full) begin
            check("rejected_data", 32'(d), 32'(next_val));
        end
        update_flags();
    endtask

    task automatic push_fill();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(next_val);
            next_val = pat_next(next_val);
        end
    endtask

    task automatic do_fill(input int exp_fill);
        int n;
        int acc0;
        push_fill();
        en   = 1'b1;
        acc0 = n_acc;
        n    = 0;
        do begin
            tick();
            n++;
            if (n == 1) check("settle_busy", 32'(busy), 32'd1);
        end while (!wrreq && n < 20);
        check("start_lat", 32'(n), 32'(SETTLE + 1));
        n = 0;
        while (wrreq && n < 40) begin
            tick();
            n++;
        end
        check("fill_len", 32'(n_acc - acc0), 32'(DEPTH));
        check("fill_cnt", 32'(fill_cnt), 32'(exp_fill));
        check("scoreboard_left", 32'(exp_q.size()), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("wrdata_hold", 32'(wrdata), 32'(next_val));
        check("led_wr_full", 32'(led_wr), 32'd0);
    endtask

    initial begin
        int n;
        int acc0;
        update_flags();
        next_val = RESET_VAL;
        #1;
        check("rst_wrreq", 32'(wrreq), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fill_cnt", 32'(fill_cnt), 32'd0);
        check("rst_wrdata", 32'(wrdata), 32'(RESET_VAL));
        check("rst_led_wr", 32'(led_wr), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First and second fills; the second resumes from the rejected word.
        do_fill(1);
        drain();
        check("led_wr_empty", 32'(led_wr), 32'd1);
        do_fill(2);

        // Permission withheld while the FIFO sits empty.
        en = 1'b0;
        drain();
        for (int i = 0; i < 50; i++) begin
            tick();
            check("en_low_wrreq", 32'(wrreq), 32'd0);
            check("en_low_busy", 32'(busy), 32'd0);
        end
        do_fill(3);

        // wrfull during SETTLE (together with wrempty) aborts without writing.
        drain();
        tick();
        check("abort_enter", 32'(busy), 32'd1);
        full_force = 1'b1;
        update_flags();
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wrreq", 32'(wrreq), 32'd0);
        en         = 1'b0;
        full_force = 1'b0;
        update_flags();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_idle_wrreq", 32'(wrreq), 32'd0);
        end
        check("abort_fill_cnt", 32'(fill_cnt), 32'd3);

        // Reset pulse while the fifth write is presented.
        en = 1'b1;
        push_fill();
        acc0 = n_acc;
        n    = 0;
        while ((n_acc - acc0) < 4 && n < 40) begin
            tick();
            n++;
        end
        check("pre_reset_wrreq", 32'(wrreq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wrreq", 32'(wrreq), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_fill_cnt", 32'(fill_cnt), 32'd0);
        check("async_wrdata", 32'(wrdata), 32'(RESET_VAL));
        exp_q.delete();
        next_val = RESET_VAL;
        drain();
        @(posedge clk);
        #1;
        check("in_reset_wrreq", 32'(wrreq), 32'd0);
        rst_n = 1'b1;
        do_fill(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wr_fifo_fill.md
Name: wr_fifo_fill

Overview:
- Write-side controller for the dual-clock test FIFO; the counterpart of the read-side drain controller.
- Waits until the FIFO reports empty, lets the flags settle, then writes a generated data pattern on consecutive cycles until the FIFO reports full, then returns to waiting.
- Sits in the write clock domain, driving the FIFO's write port directly. Also drives a status LED and a completed-fill counter.

Parameters:
- DATA_W, 8, width of wrdata and of the pattern generator.
- START_VAL, 0, first data word after reset.
- STEP, 1, increment applied after every accepted write (counter mode).
- SETTLE_CYC, 3, wait cycles after wrempty is seen before writing starts (covers dual-clock flag latency); legal range 1..15.

Ports:
- clk, input, 1, write-domain clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, start permission; sampled only in IDLE.
- wrfull, input, 1, FIFO write-side full flag.
- wrempty, input, 1, FIFO write-side empty flag.
- wrreq, output, 1, FIFO write request (registered).
- wrdata, output, DATA_W, FIFO write data (registered).
- fill_cnt, output, 8, number of completed fills; wraps 255->0.
- busy, output, 1, high in SETTLE and WRITE.
- led_wr, output, 1, combinational copy of wrempty (lit while FIFO empty).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wrreq=0, wrdata=START_VAL, fill_cnt=0, busy=0, settle counter=0.
  - Reset mid-WRITE aborts immediately: no further wrreq, pattern restarts at START_VAL.
- Accepted write: a cycle with wrreq=1 && wrfull=0. Only accepted writes advance wrdata (wrdata <= wrdata+STEP, modulo 2^DATA_W). A rejected write keeps wrdata, so no pattern value is lost or skipped.
- IDLE:
  - wrreq=0.
  - If en && wrempty: settle counter<=0, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - wrreq=0, counter increments each cycle.
  - When counter==SETTLE_CYC-1: go to WRITE and set wrreq<=1. The first write is presented SETTLE_CYC+1 cycles after wrempty is first sampled high in IDLE.
  - wrfull=1 during SETTLE: abort to IDLE, fill_cnt unchanged.
- WRITE:
  - wrreq held at 1 while wrfull=0.
  - On the cycle wrfull is sampled 1: wrreq<=0, fill_cnt<=fill_cnt+1, go to IDLE. The write request presented in that same cycle is the rejected one, and its data is re-presented in the next fill.
  - wrempty and en are ignored in WRITE.
- Simultaneous wrfull=1 and wrempty=1 (illegal from the FIFO): wrfull wins in every state.
- busy = (state==SETTLE || state==WRITE), registered alongside the state.
- Undefined state encoding: recover to IDLE with wrreq=0.

Optional Feature:
- Macro: WR_FIFO_FILL_LFSR_EN.
- Defined:
  - wrdata comes from a Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, DATA_W forced to 8, seed 8'h01 at reset (START_VAL and STEP are ignored).
  - The LFSR shifts only on accepted writes and never reaches 0.
- Undefined: counter mode as described above.

Test Plan:
- Reset release with wrempty=1, en=1, SETTLE_CYC=3, FIFO depth 16 -> wrreq rises 4 cycles later; 16 accepted writes carry wrdata 0x00..0x0F; wrfull then drops wrreq; fill_cnt=1.
- After the first fill, reader drains the FIFO and wrempty returns -> second fill starts at 0x10 (the first rejected 0x10 is re-presented); ends at 0x1F; fill_cnt=2.
- en=0 with wrempty=1 for 50 cycles -> wrreq stays 0, busy=0; raising en -> SETTLE entered the next cycle.
- wrfull pulsed high during SETTLE -> return to IDLE, no wrreq asserted, fill_cnt unchanged.
- rst_n pulsed low for 1 cycle during the 5th write -> wrreq=0 asynchronously; after release the next fill starts at 0x00, fill_cnt=0.
- WR_FIFO_FILL_LFSR_EN defined, depth 16 -> first writes 0x01,0x02,0x04,... per the polynomial; the sequence resumes from the rejected value on the next fill; wrdata never 0x00.
